// File: rtl/fu_issue_buffer.sv
// Per-FU issue buffer: NUM_CH independent in-order FIFOs with flush and ROB-age squash.
// Latency: 1 cycle push-to-head (0 cycles when PASSTHRU=1 and the channel is empty).
// Backpressure: in_ready drops when full unless the head leaves this cycle (pop or dead skip).
module fu_issue_buffer #(
    parameter int NUM_CH   = 4,
    parameter int DEPTH    = 2,
    parameter int DATA_W   = 64,
    parameter int ROB_W    = 5,
    parameter int PASSTHRU = 0,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CH-1:0]                i_in_valid,
    output logic [NUM_CH-1:0]                o_in_ready,
    input  logic [NUM_CH-1:0][DATA_W-1:0]    i_in_data,
    input  logic [NUM_CH-1:0][ROB_W-1:0]     i_in_rob_idx,
    output logic [NUM_CH-1:0]                o_out_valid,
    input  logic [NUM_CH-1:0]                i_out_ready,
    output logic [NUM_CH-1:0][DATA_W-1:0]    o_out_data,
    output logic [NUM_CH-1:0][ROB_W-1:0]     o_out_rob_idx,
    input  logic                             i_flush_valid,
    input  logic                             i_recover_valid,
    input  logic [ROB_W-1:0]                 i_recover_rob_idx,
    input  logic [ROB_W-1:0]                 i_rob_head_idx,
    output logic [NUM_CH-1:0][CNT_W-1:0]     o_count,
    output logic                             o_busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Distance from the ROB head decides age, so wrap-around of the index is harmless.
    function automatic logic f_younger(input logic [ROB_W-1:0] x);
        logic [ROB_W-1:0] w_dx;
        logic [ROB_W-1:0] w_dr;
        w_dx = x - i_rob_head_idx;
        w_dr = i_recover_rob_idx - i_rob_head_idx;
        return w_dx > w_dr;
    endfunction

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [NUM_CH-1:0] w_nonempty;

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        logic [DEPTH-1:0]  r_alloc;
        logic [DEPTH-1:0]  r_live;
        logic [DATA_W-1:0] r_data [DEPTH];
        logic [ROB_W-1:0]  r_rob  [DEPTH];
        logic [PTR_W-1:0]  r_head;
        logic [PTR_W-1:0]  r_tail;
        logic [CNT_W-1:0]  r_count;

        logic w_empty, w_dead, w_head_yng, w_in_yng, w_pt;
        logic w_vld, w_pop, w_rdy, w_push, w_wr, w_deq;

        assign w_empty    = (r_count == '0);
        // A squashed (dead) slot still holds its place until it reaches the head.
        assign w_dead     = r_alloc[r_head] && !r_live[r_head];
        assign w_head_yng = i_recover_valid && f_younger(r_rob[r_head]);
        assign w_in_yng   = i_recover_valid && f_younger(i_in_rob_idx[g]);
        assign w_pt       = (PASSTHRU != 0) && w_empty;

        assign w_vld  = !i_flush_valid &&
                        (w_pt ? (i_in_valid[g] && !w_in_yng)
                              : (r_live[r_head] && !w_head_yng));
        assign w_pop  = w_vld && i_out_ready[g];
        assign w_rdy  = (r_count < CNT_W'(DEPTH)) || w_pop || w_dead;
        assign w_push = i_in_valid[g] && w_rdy;
        // Squashed or flushed pushes still handshake but never occupy a slot;
        // a fall-through entry consumed this cycle is not stored either.
        assign w_wr   = w_push && !i_flush_valid && !w_in_yng && !(w_pt && w_pop);
        assign w_deq  = !i_flush_valid && ((w_pop && !w_pt) || w_dead);

        assign o_in_ready[g]    = w_rdy;
        assign o_out_valid[g]   = w_vld;
        assign o_out_data[g]    = !w_vld ? '0 : (w_pt ? i_in_data[g]    : r_data[r_head]);
        assign o_out_rob_idx[g] = !w_vld ? '0 : (w_pt ? i_in_rob_idx[g] : r_rob[r_head]);
        assign o_count[g]       = r_count;
        assign w_nonempty[g]    = !w_empty;

        // Slot state update: flush wins, then squash marking, then dequeue, then enqueue
        // (enqueue last so a full-throughput replace of the head slot keeps the new entry).
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_alloc <= '0;
                r_live  <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_data[i] <= '0;
                    r_rob[i]  <= '0;
                end
            end else if (i_flush_valid) begin
                r_alloc <= '0;
                r_live  <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (i_recover_valid) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (r_live[i] && f_younger(r_rob[i])) begin
                            r_live[i] <= 1'b0;
                        end
                    end
                end
                if (w_deq) begin
                    r_alloc[r_head] <= 1'b0;
                    r_live[r_head]  <= 1'b0;
                    r_head          <= f_inc(r_head);
                end
                if (w_wr) begin
                    r_alloc[r_tail] <= 1'b1;
                    r_live[r_tail]  <= 1'b1;
                    r_data[r_tail]  <= i_in_data[g];
                    r_rob[r_tail]   <= i_in_rob_idx[g];
                    r_tail          <= f_inc(r_tail);
                end
                r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_deq);
            end
        end
    end

    assign o_busy = |w_nonempty;

endmodule
